// File: rtl/slp_train_ctrl.sv
// Sequencer and weight store for a single-layer perceptron: serial MAC inference plus serial weight update.
// Build option: define SLP_CTRL_SAT_EN to saturate updated weights; otherwise they wrap to W_PREC bits.
module slp_train_ctrl #(
   parameter  int IN     = 8,
   parameter  int I_PREC = 8,
   parameter  int W_PREC = 16,
   parameter  int R_PREC = 4,
   parameter  int P_PREC = 8,
   localparam int WEIGHT = IN + 1,
   localparam int IDX_W  = $clog2(WEIGHT)
) (
   input  logic                     clk,
   input  logic                     reset_,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN*I_PREC-1:0]     in_data,
   input  logic signed [P_PREC-1:0] label,
   input  logic                     train_en,
   input  logic [R_PREC-1:0]        rate,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic signed [P_PREC-1:0] infer,
   output logic                     miss,
   input  logic                     w_wr_en,
   input  logic [IDX_W-1:0]         w_wr_idx,
   input  logic signed [W_PREC-1:0] w_wr_data,
   input  logic [IDX_W-1:0]         w_rd_idx,
   output logic signed [W_PREC-1:0] w_rd_data,
   output logic [15:0]              err_cnt,
   input  logic                     err_clr
);
   localparam int ACC_W = I_PREC + W_PREC + IDX_W + 1;
   localparam int UPD_W = W_PREC + R_PREC + P_PREC + I_PREC + 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN);
`ifdef SLP_CTRL_SAT_EN
   localparam logic signed [UPD_W-1:0] W_MAX = UPD_W'((64'sd1 <<< (W_PREC - 1)) - 64'sd1);
   localparam logic signed [UPD_W-1:0] W_MIN = ~W_MAX;
`endif

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_RESP} state_t;

   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_idx;
   logic [IN*I_PREC-1:0]      r_x;
   logic signed [P_PREC-1:0]  r_label;
   logic [R_PREC-1:0]         r_rate;
   logic                      r_train;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [P_PREC:0]    r_err;
   logic signed [P_PREC-1:0]  r_infer;
   logic                      r_miss;
   logic [15:0]               r_err_cnt;
   logic signed [W_PREC-1:0]  r_w [WEIGHT];

   logic signed [I_PREC-1:0]  w_xv [WEIGHT];
   logic signed [I_PREC-1:0]  w_x_cur;
   logic signed [W_PREC-1:0]  w_w_cur;
   logic signed [ACC_W-1:0]   w_mac_sum;
   logic signed [UPD_W-1:0]   w_upd_sum;
   logic signed [P_PREC-1:0]  w_act_infer;
   logic signed [P_PREC:0]    w_act_err;
   logic                      w_act_miss;
   logic                      w_accept;
   logic                      w_wr_ok;
   logic [IDX_W-1:0]          w_idx_nxt;

   function automatic logic signed [W_PREC-1:0] fit_w(input logic signed [UPD_W-1:0] v);
`ifdef SLP_CTRL_SAT_EN
      if (v > W_MAX)
         return W_PREC'(W_MAX);
      else if (v < W_MIN)
         return W_PREC'(W_MIN);
      else
         return W_PREC'(v);
`else
      return W_PREC'(v);
`endif
   endfunction

   // x[IN] is the constant bias input
   always_comb begin
      for (int i = 0; i < IN; i++)
         w_xv[i] = r_x[i*I_PREC +: I_PREC];
      w_xv[IN] = I_PREC'(1);
   end

   assign w_x_cur     = w_xv[r_idx];
   assign w_w_cur     = r_w[r_idx];
   assign w_mac_sum   = r_acc + ACC_W'(w_w_cur) * ACC_W'(w_x_cur);
   assign w_upd_sum   = UPD_W'(w_w_cur)
                      + UPD_W'($signed({1'b0, r_rate})) * UPD_W'(r_err) * UPD_W'(w_x_cur);
   assign w_act_infer = r_acc[ACC_W-1] ? {P_PREC{1'b1}} : P_PREC'(1);
   assign w_act_err   = (P_PREC+1)'(r_label) - (P_PREC+1)'(w_act_infer);
   assign w_act_miss  = (w_act_err != '0);
   assign w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

   // Preload owns the cycle, so a sample cannot be accepted alongside it
   assign in_ready  = reset_ && (r_state == S_IDLE) && !w_wr_en;
   assign w_accept  = in_valid && in_ready;
   assign w_wr_ok   = (r_state == S_IDLE) && w_wr_en && (w_wr_idx <= LAST_IDX);
   assign res_valid = (r_state == S_RESP);
   assign infer     = r_infer;
   assign miss      = r_miss;
   assign err_cnt   = r_err_cnt;
   assign w_rd_data = (w_rd_idx <= LAST_IDX) ? r_w[w_rd_idx] : '0;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
         S_MAC:   if (r_idx == LAST_IDX) w_state_nxt = S_ACT;
         S_ACT:   w_state_nxt = (r_train && w_act_miss) ? S_UPD : S_RESP;
         S_UPD:   if (r_idx == LAST_IDX) w_state_nxt = S_RESP;
         S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_idx   <= '0;
         r_x     <= '0;
         r_label <= '0;
         r_rate  <= '0;
         r_train <= 1'b0;
         r_acc   <= '0;
         r_err   <= '0;
         r_infer <= '0;
         r_miss  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x     <= in_data;
                  r_label <= label;
                  r_rate  <= rate;
                  r_train <= train_en;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
            end
            S_MAC: begin
               r_acc <= w_mac_sum;
               r_idx <= w_idx_nxt;
            end
            S_ACT: begin
               r_infer <= w_act_infer;
               r_err   <= w_act_err;
               r_miss  <= w_act_miss;
               r_idx   <= '0;
            end
            S_UPD:   r_idx <= w_idx_nxt;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < WEIGHT; i++)
            r_w[i] <= '0;
      end else if (w_wr_ok) begin
         r_w[w_wr_idx] <= w_wr_data;
      end else if (r_state == S_UPD) begin
         r_w[r_idx] <= fit_w(w_upd_sum);
      end
   end

   // A clear in the same cycle as a counted miss leaves the counter at zero
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         r_err_cnt <= '0;
      else if (err_clr)
         r_err_cnt <= '0;
      else if ((r_state == S_ACT) && w_act_miss && (r_err_cnt != 16'hFFFF))
         r_err_cnt <= r_err_cnt + 16'd1;
   end

endmodule

// File: tb/tb_slp_train_ctrl.sv
// Scoreboard bench for slp_train_ctrl: directed scenarios plus randomized samples against a behavioural perceptron model.
module tb_slp_train_ctrl;
   localparam int IN     = 8;
   localparam int I_PREC = 8;
   localparam int W_PREC = 16;
   localparam int R_PREC = 4;
   localparam int P_PREC = 8;
   localparam int WEIGHT = IN + 1;
   localparam int IDX_W  = $clog2(WEIGHT);

   logic                 clk = 1'b0;
   logic                 reset_ = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [IN*I_PREC-1:0] in_data = '0;
   logic [P_PREC-1:0]    label = '0;
   logic                 train_en = 1'b0;
   logic [R_PREC-1:0]    rate = '0;
   logic                 res_valid;
   logic                 res_ready = 1'b1;
   logic [P_PREC-1:0]    infer;
   logic                 miss;
   logic                 w_wr_en = 1'b0;
   logic [IDX_W-1:0]     w_wr_idx = '0;
   logic [W_PREC-1:0]    w_wr_data = '0;
   logic [IDX_W-1:0]     w_rd_idx = '0;
   logic [W_PREC-1:0]    w_rd_data;
   logic [15:0]          err_cnt;
   logic                 err_clr = 1'b0;

   slp_train_ctrl #(.IN(IN), .I_PREC(I_PREC), .W_PREC(W_PREC), .R_PREC(R_PREC), .P_PREC(P_PREC)) dut (
      .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .label(label), .train_en(train_en), .rate(rate), .res_valid(res_valid), .res_ready(res_ready),
      .infer(infer), .miss(miss), .w_wr_en(w_wr_en), .w_wr_idx(w_wr_idx), .w_wr_data(w_wr_data),
      .w_rd_idx(w_rd_idx), .w_rd_data(w_rd_data), .err_cnt(err_cnt), .err_clr(err_clr)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int infer;
      bit miss;
      int lat;
   } exp_t;

   exp_t   q[$];
   longint mw[WEIGHT];
   int     mcnt = 0;
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     acc_cyc = 0;
   int     rr_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   function automatic longint fitw(input longint v);
      longint hi = (64'sd1 <<< (W_PREC - 1)) - 1;
      longint lo = -(64'sd1 <<< (W_PREC - 1));
      longint r  = v;
`ifdef SLP_CTRL_SAT_EN
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`else
      while (r > hi) r = r - (64'sd1 <<< W_PREC);
      while (r < lo) r = r + (64'sd1 <<< W_PREC);
`endif
      return r;
   endfunction

   // Perceptron rule at sample level: one dot product, one sign, one vector update
   function automatic void model_push(input logic [IN*I_PREC-1:0] xp, input int lab, input int rt, input bit tr);
      longint x[WEIGHT];
      longint acc = 0;
      int     inf, err;
      exp_t   e;
      for (int i = 0; i < IN; i++) x[i] = longint'($signed(xp[i*I_PREC +: I_PREC]));
      x[IN] = 1;
      for (int i = 0; i < WEIGHT; i++) acc += mw[i] * x[i];
      inf = (acc >= 0) ? 1 : -1;
      err = lab - inf;
      e.infer = inf;
      e.miss  = (err != 0);
      e.lat   = (tr && e.miss) ? 2 * WEIGHT + 1 : WEIGHT + 1;
      if (e.miss && mcnt < 65535) mcnt++;
      if (tr && e.miss)
         for (int i = 0; i < WEIGHT; i++) mw[i] = fitw(mw[i] + longint'(rt) * err * x[i]);
      q.push_back(e);
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
         0:       res_ready = 1'b1;
         1:       res_ready = ($urandom_range(0, 3) != 0);
         default: res_ready = 1'b0;
      endcase
   end

   // Monitor: compares every presented result against the head of the scoreboard
   initial begin : monitor
      bit   prev_rv = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_) begin
            prev_rv = 1'b0;
         end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (res_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  e = q[0];
                  chk("infer", longint'($signed(infer)), e.infer);
                  chk("miss", miss, e.miss);
                  chk("in_ready_in_resp", in_ready, 0);
                  if (!prev_rv) chk("latency", cyc - acc_cyc, e.lat);
                  if (res_ready) void'(q.pop_front());
               end
            end
            prev_rv = res_valid;
         end
      end
   end

   task automatic send(input logic [IN*I_PREC-1:0] xp, input int lab, input int rt, input bit tr, input bit wr_same);
      int n = 0;
      @(posedge clk);
      #1;
      in_data  = xp;
      label    = P_PREC'(lab);
      rate     = R_PREC'(rt);
      train_en = tr;
      in_valid = 1'b1;
      if (wr_same) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = IDX_W'(2);
         w_wr_data = W_PREC'(7);
         @(negedge clk);
         chk("wr_priority_in_ready", in_ready, 0);
         @(posedge clk);
         #1 w_wr_en = 1'b0;
         mw[2] = 7;
      end
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_now("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      model_push(xp, lab, rt, tr);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      label    = P_PREC'($urandom);
      rate     = R_PREC'($urandom);
      train_en = 1'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || res_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail_now("result_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int idx, input int data);
      @(posedge clk);
      #1;
      w_wr_en   = 1'b1;
      w_wr_idx  = IDX_W'(idx);
      w_wr_data = W_PREC'(data);
      @(posedge clk);
      #1 w_wr_en = 1'b0;
      if (idx < WEIGHT) mw[idx] = fitw(longint'(data));
   endtask

   task automatic check_w(input string tag);
      for (int i = 0; i < WEIGHT; i++) begin
         w_rd_idx = IDX_W'(i);
         #1;
         chk($sformatf("%s_w%0d", tag, i), longint'($signed(w_rd_data)), mw[i]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_ = 1'b0;
      q.delete();
      for (int i = 0; i < WEIGHT; i++) mw[i] = 0;
      mcnt = 0;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_infer", infer, 0);
      chk("rst_miss", miss, 0);
      chk("rst_err_cnt", err_cnt, 0);
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [IN*I_PREC-1:0] all1 = {IN{8'd1}};
      logic [IN*I_PREC-1:0] xr;
      int n;

      for (int i = 0; i < WEIGHT; i++) mw[i] = 0;
      do_reset();
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      check_w("reset");

      send(all1, 1, 1, 1, 0);
      wait_done();
      check_w("correct");
      chk("err_cnt_correct", err_cnt, mcnt);

      send(all1, -1, 1, 1, 0);
      wait_done();
      check_w("update");
      w_rd_idx = IDX_W'(0);
      #1 chk("w0_after_update", longint'($signed(w_rd_data)), -2);
      chk("err_cnt_one", err_cnt, 1);

      send(all1, -1, 1, 1, 0);
      wait_done();
      check_w("resend");

      do_reset();
      send(all1, -1, 1, 0, 0);
      wait_done();
      check_w("no_train");
      chk("err_cnt_no_train", err_cnt, 1);

      send(all1, -1, 1, 0, 0);
      repeat (9) @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      mcnt = 0;
      wait_done();
      chk("err_clr_wins", err_cnt, 0);

      do_reset();
      preload(0, -32768);
      preload(1, 32767);
      send(64'h0000_0000_0000_0104, 1, 1, 1, 0);
      wait_done();
      check_w("boundary");
      w_rd_idx = IDX_W'(0);
      #1 chk("w0_boundary", longint'($signed(w_rd_data)), -32760);
      w_rd_idx = IDX_W'(1);
`ifdef SLP_CTRL_SAT_EN
      #1 chk("w1_boundary", longint'($signed(w_rd_data)), 32767);
`else
      #1 chk("w1_boundary", longint'($signed(w_rd_data)), -32767);
`endif

      rr_mode = 2;
      send(all1, -1, 0, 1, 0);
      w_wr_en   = 1'b1;
      w_wr_idx  = IDX_W'(0);
      w_wr_data = W_PREC'(5);
      repeat (3) @(posedge clk);
      #1 w_wr_en = 1'b0;
      n = 0;
      while (!res_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) fail_now("resp_wait");
      repeat (5) @(negedge clk);
      rr_mode = 0;
      wait_done();
      check_w("busy_write");

      preload(9, 123);
      check_w("oob_write");
      send(all1, 1, 2, 1, 1);
      wait_done();
      check_w("priority");

      do_reset();
      send(all1, -1, 1, 1, 0);
      repeat (13) @(posedge clk);
      #3 reset_ = 1'b0;
      q.delete();
      for (int i = 0; i < WEIGHT; i++) mw[i] = 0;
      mcnt = 0;
      #1 chk("midrst_res_valid", res_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      check_w("midrst");
      @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk);
      chk("midrst_err_cnt", err_cnt, 0);

      rr_mode = 1;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 4) == 0) preload($urandom_range(0, 15), $urandom_range(0, 65535) - 32768);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1 err_clr = 1'b1;
            @(posedge clk);
            #1 err_clr = 1'b0;
            mcnt = 0;
         end
         xr = {$urandom, $urandom};
         send(xr, ($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 0);
         wait_done();
         chk("rand_err_cnt", err_cnt, mcnt);
         if (it % 10 == 9) check_w("rand");
      end
      rr_mode = 0;
      check_w("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/slp_train_ctrl.md
Name: slp_train_ctrl

Overview:
- Sequencer and weight store for a single-layer perceptron.
- Accepts one training sample per handshake and runs a serial multiply-accumulate over the IN inputs plus bias to produce a ±1 inference.
- When training is enabled and the inference is wrong, applies the perceptron weight update serially.
- Sits between the sample source (testbench or DMA) and the weight-consumer logic; owns the only copy of the weights.

Parameters:
- IN, 8, number of inputs per sample; WEIGHT = IN+1 (index IN is the bias)
- I_PREC, 8, signed input width
- W_PREC, 16, signed weight width
- R_PREC, 4, unsigned learning-rate width
- P_PREC, 8, signed inference/label width

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  controller can accept a sample
- in_data  in  IN*I_PREC  packed signed inputs; element i at [i*I_PREC +: I_PREC]
- label  in  P_PREC  expected result, +1 or -1
- train_en  in  1  1 = update weights on error; 0 = inference only
- rate  in  R_PREC  learning rate, unsigned integer
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- infer  out  P_PREC  inference result, +1 or -1
- miss  out  1  infer != label
- w_wr_en  in  1  weight preload strobe
- w_wr_idx  in  $clog2(WEIGHT)  preload index
- w_wr_data  in  W_PREC  preload value
- w_rd_idx  in  $clog2(WEIGHT)  readout index
- w_rd_data  out  W_PREC  combinational read of weight[w_rd_idx]
- err_cnt  out  16  count of missed samples, saturates at 16'hFFFF
- err_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (reset_ low, asynchronous):
  - State goes to IDLE; all weights 0; sample/label/rate/train_en registers 0; accumulator 0; err_cnt 0.
  - Outputs: in_ready 0 while reset_ is low; res_valid 0; infer 0; miss 0.
  - Reset mid-operation discards the sample in flight; no partial result is ever presented.
- States: IDLE, MAC, ACT, UPD, RESP.
- IDLE:
  - in_ready = 1 and !w_wr_en.
  - A handshake (in_valid & in_ready) latches in_data, label, rate and train_en, clears the accumulator, sets idx = 0, and moves to MAC.
- MAC:
  - Runs WEIGHT cycles, one term per cycle: acc += w[idx]*x[idx], with x[IN] = 1.
  - Accumulator is signed, I_PREC+W_PREC+$clog2(WEIGHT)+1 bits, so it never overflows.
  - After idx = IN, go to ACT.
- ACT (1 cycle):
  - infer_r = +1 if acc >= 0, else -1.
  - err = label - infer_r, giving -2, 0 or +2.
  - miss_r = (err != 0).
  - err_cnt increments if miss_r.
  - If train_en and miss_r: set idx = 0 and go to UPD; otherwise go to RESP.
- UPD:
  - Runs WEIGHT cycles: w[idx] += rate*err*x[idx], computed at full width, then written back as W_PREC.
  - After idx = IN, go to RESP.
- RESP:
  - res_valid = 1; infer and miss are held stable until res_ready.
  - On res_valid & res_ready, go to IDLE (in_ready high next cycle).
- Latency (accept edge to res_valid high):
  - WEIGHT+1 cycles with no update (10 at defaults).
  - 2*WEIGHT+1 cycles with an update (19 at defaults).
- Weight preload:
  - Accepted only in IDLE; w_wr_en in any other state is ignored.
  - w_wr_idx >= WEIGHT is ignored.
  - w_wr_en has priority over a sample handshake in the same cycle: in_ready is low that cycle.
- Inputs are not sampled outside IDLE: in_data, label, rate and train_en may change freely.
- err_clr clears err_cnt. If err_clr and an ACT increment occur in the same cycle, the clear wins and the result is 0.
- rate = 0 with train_en: UPD still runs all WEIGHT cycles and the weights are unchanged.
- Values are raw integers; fixed-point scaling belongs to the surrounding datapath.

Optional Feature:
- Macro: SLP_CTRL_SAT_EN
- Defined: the UPD result saturates to [-2^(W_PREC-1), 2^(W_PREC-1)-1].
- Undefined: the UPD result is truncated to W_PREC bits (two's-complement wrap).
- MAC and err_cnt behaviour is identical in both builds.

Test Plan:
- Reset, then read all 9 weights → all 0. Send x = all 1, label = +1, rate = 1, train_en = 1 → infer = +1, miss = 0, res_valid high 10 cycles after accept, weights unchanged.
- From zero weights, x = all 1, label = -1, rate = 1, train_en = 1 → infer = +1, miss = 1, all 9 weights = -2, err_cnt = 1, latency 19 cycles. Resend the same sample → acc = -18, infer = -1, miss = 0.
- Same as the previous case but train_en = 0 → miss = 1, weights remain 0, latency 10 cycles.
- Preload w0 = -32768, w1 = 32767, others 0; x0 = 4, x1 = 1, others 0; label = +1, rate = 1, train_en = 1 → infer = -1, w0 = -32760. w1 = 32767 with SLP_CTRL_SAT_EN defined; w1 = -32767 without it.
- Hold res_ready low for 5 cycles in RESP → res_valid, infer and miss stable, in_ready = 0. Assert w_wr_en with idx 0, data 5 during MAC → w0 unchanged.
- Pull reset_ low in UPD cycle 4 → res_valid = 0 and weights = 0 immediately. Assert err_clr in the same cycle as a miss → err_cnt = 0.
